// File: rtl/traffic_pkg.sv
// Shared types and default timing for the traffic controller and crossing heads.
package traffic_pkg;

  // Pedestrian crossing-head state encoding
  typedef enum logic [1:0] {
    PED_IDLE    = 2'd0,
    PED_REQUEST = 2'd1,
    PED_WALK    = 2'd2,
    PED_CLEAR   = 2'd3
  } ped_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_CLEAR_CYCLES    = 12;
  localparam int unsigned DEF_FLASH_DIV       = 2;
  localparam int unsigned DEF_CNT_W           = 4;

  // Active level of the controller's walk grant
  localparam logic WALK_ON = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter,
// debounced level and a one-cycle press pulse on its rising edge.
module btn_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples disagreeing with the debounced level
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  // Synchroniser and debounce registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/ped_crossing_request.sv
// Pedestrian crossing head: holds a debounced request to the controller
// until walk is granted, and drives WAIT / WALK / DON'T-WALK lamps with a
// flashing clearance countdown. Define PED_AUDIO_EN to add the beep output.
module ped_crossing_request
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CLEAR_CYCLES    = DEF_CLEAR_CYCLES,
  parameter int unsigned FLASH_DIV       = DEF_FLASH_DIV,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             walk,
  output logic             pedestrian_button,
  output logic             wait_lamp,
  output logic             walk_lamp,
  output logic             dont_walk_lamp,
`ifdef PED_AUDIO_EN
  output logic             beep,
`endif
  output logic [CNT_W-1:0] countdown
);

  localparam logic [1:0] ST_IDLE    = PED_IDLE;
  localparam logic [1:0] ST_REQUEST = PED_REQUEST;
  localparam logic [1:0] ST_WALK    = PED_WALK;
  localparam logic [1:0] ST_CLEAR   = PED_CLEAR;

  localparam int unsigned FL_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  logic             press;
  logic             unused_btn_level;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FL_W-1:0]  fdiv_q, fdiv_d;
  logic             pend_q, pend_d;
  logic             flash_tick;
  logic             pb_q, pb_d;
  logic             wait_q, wait_d;
  logic             wl_q, wl_d;
  logic             dw_q, dw_d;
`ifdef PED_AUDIO_EN
  logic             beep_q, beep_d;
`endif

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_raw_i(btn_raw),
    .level_o  (unused_btn_level),
    .press_o  (press)
  );

  // Next-state, countdown, pending and lamp decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fdiv_d     = fdiv_q;
    pend_d     = pend_q;
    flash_tick = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (walk == WALK_ON)  state_d = ST_WALK;
        else if (press)       state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (walk == WALK_ON)  state_d = ST_WALK;
      end
      ST_WALK: begin
        if (press) pend_d = 1'b1;
        if (walk != WALK_ON) begin
          state_d = ST_CLEAR;
          cnt_d   = CNT_W'(CLEAR_CYCLES - 1);
          fdiv_d  = '0;
        end
      end
      default: begin
        if (walk == WALK_ON) begin
          state_d = ST_WALK;
          cnt_d   = '0;
          pend_d  = pend_q | press;
        end else if (cnt_q == '0) begin
          // A press in the final clearance cycle still counts as a request
          state_d = (pend_q || press) ? ST_REQUEST : ST_IDLE;
          pend_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          pend_d = pend_q | press;
          if (fdiv_q == FL_W'(FLASH_DIV - 1)) begin
            fdiv_d     = '0;
            flash_tick = 1'b1;
          end else begin
            fdiv_d = fdiv_q + FL_W'(1);
          end
        end
      end
    endcase

    pb_d   = (state_d == ST_REQUEST);
    wait_d = (state_d == ST_REQUEST);
    wl_d   = (state_d == ST_WALK);
    dw_d   = 1'b1;
    if (state_d == ST_WALK) begin
      dw_d = 1'b0;
    end else if (state_d == ST_CLEAR && state_q == ST_CLEAR) begin
      dw_d = dw_q ^ flash_tick;
    end

`ifdef PED_AUDIO_EN
    beep_d = 1'b0;
    if (state_d == ST_WALK) begin
      beep_d = ~beep_q;
    end else if (state_d == ST_CLEAR && state_q == ST_CLEAR) begin
      beep_d = 1'b1;
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fdiv_q  <= '0;
      pend_q  <= 1'b0;
      pb_q    <= 1'b0;
      wait_q  <= 1'b0;
      wl_q    <= 1'b0;
      dw_q    <= 1'b1;
`ifdef PED_AUDIO_EN
      beep_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fdiv_q  <= fdiv_d;
      pend_q  <= pend_d;
      pb_q    <= pb_d;
      wait_q  <= wait_d;
      wl_q    <= wl_d;
      dw_q    <= dw_d;
`ifdef PED_AUDIO_EN
      beep_q  <= beep_d;
`endif
    end
  end

  assign pedestrian_button = pb_q;
  assign wait_lamp         = wait_q;
  assign walk_lamp         = wl_q;
  assign dont_walk_lamp    = dw_q;
  assign countdown         = cnt_q;
`ifdef PED_AUDIO_EN
  assign beep              = beep_q;
`endif

endmodule

// File: tb/tb_ped_crossing_request.sv
// Bench for ped_crossing_request: directed scenarios plus random
// button/walk traffic checked against a behavioural reference model.
module tb_ped_crossing_request;

  localparam int DB = 4;
  localparam int CC = 12;
  localparam int FD = 2;
  localparam int CW = 4;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_WALK = 2;
  localparam int M_CLR  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_raw;
  logic          walk;
  logic          pedestrian_button;
  logic          wait_lamp;
  logic          walk_lamp;
  logic          dont_walk_lamp;
  logic [CW-1:0] countdown;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_s1 = 0, m_s2 = 0;
  int m_hist [DB];
  int m_level = 0, m_press = 0;
  int m_mode = M_IDLE, m_k = 0, m_pend = 0;

  always #5 clk = ~clk;

  ped_crossing_request #(
    .DEBOUNCE_CYCLES(DB),
    .CLEAR_CYCLES   (CC),
    .FLASH_DIV      (FD),
    .CNT_W          (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_raw          (btn_raw),
    .walk             (walk),
    .pedestrian_button(pedestrian_button),
    .wait_lamp        (wait_lamp),
    .walk_lamp        (walk_lamp),
    .dont_walk_lamp   (dont_walk_lamp),
    .countdown        (countdown)
  );

  // Behavioural model: sample history for the debouncer, elapsed-cycle count for clearance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0;
      for (int i = 0; i < DB; i++) m_hist[i] = 0;
      m_mode = M_IDLE; m_k = 0; m_pend = 0;
    end else begin
      int sample;
      bool_blk: begin
        int all_diff;
        case (m_mode)
          M_IDLE: begin
            if (walk) m_mode = M_WALK;
            else if (m_press != 0) m_mode = M_REQ;
          end
          M_REQ: if (walk) m_mode = M_WALK;
          M_WALK: begin
            if (m_press != 0) m_pend = 1;
            if (!walk) begin m_mode = M_CLR; m_k = 0; end
          end
          default: begin
            if (walk) begin
              m_mode = M_WALK;
              if (m_press != 0) m_pend = 1;
            end else if (m_k == CC - 1) begin
              m_mode = (m_pend != 0 || m_press != 0) ? M_REQ : M_IDLE;
              m_pend = 0;
            end else begin
              m_k++;
              if (m_press != 0) m_pend = 1;
            end
          end
        endcase
        sample = m_s2;
        for (int i = DB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = sample;
        all_diff = 1;
        for (int i = 0; i < DB; i++) if (m_hist[i] == m_level) all_diff = 0;
        m_press = 0;
        if (all_diff != 0) begin
          m_level = 1 - m_level;
          m_press = m_level;
        end
        m_s2 = m_s1;
        m_s1 = btn_raw ? 1 : 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn_raw = 1'b0; walk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_raw = 1'b0; walk = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (pedestrian_button !== 1'b0) begin n_err++; $display("FAIL reset pedestrian_button got %b exp 0", pedestrian_button); end
    n_cmp++; if (wait_lamp !== 1'b0) begin n_err++; $display("FAIL reset wait_lamp got %b exp 0", wait_lamp); end
    n_cmp++; if (walk_lamp !== 1'b0) begin n_err++; $display("FAIL reset walk_lamp got %b exp 0", walk_lamp); end
    n_cmp++; if (dont_walk_lamp !== 1'b1) begin n_err++; $display("FAIL reset dont_walk_lamp got %b exp 1", dont_walk_lamp); end
    n_cmp++; if (countdown !== CW'(0)) begin n_err++; $display("FAIL reset countdown got %0d exp 0", countdown); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    btn_raw = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (pedestrian_button !== 1'b0) begin n_err++; $display("FAIL press_early pedestrian_button got %b exp 0", pedestrian_button); end
    @(negedge clk);
    n_cmp++; if (pedestrian_button !== 1'b1) begin n_err++; $display("FAIL press_c7 pedestrian_button got %b exp 1", pedestrian_button); end
    n_cmp++; if (wait_lamp !== 1'b1) begin n_err++; $display("FAIL press_c7 wait_lamp got %b exp 1", wait_lamp); end
    walk = 1'b1;
    @(negedge clk);
    n_cmp++; if (pedestrian_button !== 1'b0) begin n_err++; $display("FAIL grant pedestrian_button got %b exp 0", pedestrian_button); end
    n_cmp++; if (wait_lamp !== 1'b0) begin n_err++; $display("FAIL grant wait_lamp got %b exp 0", wait_lamp); end
    n_cmp++; if (walk_lamp !== 1'b1) begin n_err++; $display("FAIL grant walk_lamp got %b exp 1", walk_lamp); end
    n_cmp++; if (dont_walk_lamp !== 1'b0) begin n_err++; $display("FAIL grant dont_walk_lamp got %b exp 0", dont_walk_lamp); end
    repeat (2) @(negedge clk);
    btn_raw = 1'b0;
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    do_reset();
    pat = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      btn_raw = pat[i];
      @(negedge clk);
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++; if (pedestrian_button !== 1'b0) begin n_err++; $display("FAIL bounce cyc %0d pedestrian_button got %b exp 0", i, pedestrian_button); end
    end
  endtask

  task automatic test_clearance();
    do_reset();
    walk = 1'b1;
    repeat (3) @(negedge clk);
    walk = 1'b0;
    for (int k = 0; k < CC; k++) begin
      logic exp_dw;
      exp_dw = (((k / FD) % 2) == 0);
      @(negedge clk);
      n_cmp++; if (countdown !== CW'(CC - 1 - k)) begin n_err++; $display("FAIL clear k%0d countdown got %0d exp %0d", k, countdown, CC - 1 - k); end
      n_cmp++; if (dont_walk_lamp !== exp_dw) begin n_err++; $display("FAIL clear k%0d dont_walk_lamp got %b exp %b", k, dont_walk_lamp, exp_dw); end
    end
    @(negedge clk);
    n_cmp++; if (countdown !== CW'(0)) begin n_err++; $display("FAIL clear_end countdown got %0d exp 0", countdown); end
    n_cmp++; if (dont_walk_lamp !== 1'b1) begin n_err++; $display("FAIL clear_end dont_walk_lamp got %b exp 1", dont_walk_lamp); end
    n_cmp++; if (pedestrian_button !== 1'b0) begin n_err++; $display("FAIL clear_end pedestrian_button got %b exp 0", pedestrian_button); end
  endtask

  task automatic test_pending();
    do_reset();
    walk = 1'b1;
    @(negedge clk);
    btn_raw = 1'b1;
    repeat (8) @(negedge clk);
    btn_raw = 1'b0;
    n_cmp++; if (walk_lamp !== 1'b1) begin n_err++; $display("FAIL pend walk_lamp got %b exp 1", walk_lamp); end
    walk = 1'b0;
    repeat (CC) @(negedge clk);
    n_cmp++; if (pedestrian_button !== 1'b0) begin n_err++; $display("FAIL pend_last pedestrian_button got %b exp 0", pedestrian_button); end
    @(negedge clk);
    n_cmp++; if (pedestrian_button !== 1'b1) begin n_err++; $display("FAIL pend_req pedestrian_button got %b exp 1", pedestrian_button); end
    n_cmp++; if (wait_lamp !== 1'b1) begin n_err++; $display("FAIL pend_req wait_lamp got %b exp 1", wait_lamp); end
  endtask

  task automatic test_regrant();
    do_reset();
    walk = 1'b1;
    repeat (2) @(negedge clk);
    walk = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++; if (countdown !== CW'(5)) begin n_err++; $display("FAIL regrant_pre countdown got %0d exp 5", countdown); end
    walk = 1'b1;
    @(negedge clk);
    n_cmp++; if (walk_lamp !== 1'b1) begin n_err++; $display("FAIL regrant walk_lamp got %b exp 1", walk_lamp); end
    n_cmp++; if (countdown !== CW'(0)) begin n_err++; $display("FAIL regrant countdown got %0d exp 0", countdown); end
    n_cmp++; if (dont_walk_lamp !== 1'b0) begin n_err++; $display("FAIL regrant dont_walk_lamp got %b exp 0", dont_walk_lamp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_raw = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++; if (pedestrian_button !== 1'b1) begin n_err++; $display("FAIL rstmid_pre pedestrian_button got %b exp 1", pedestrian_button); end
    #2;
    rst = 1'b1; btn_raw = 1'b0;
    #1;
    n_cmp++; if (pedestrian_button !== 1'b0) begin n_err++; $display("FAIL rstmid pedestrian_button got %b exp 0", pedestrian_button); end
    n_cmp++; if (wait_lamp !== 1'b0) begin n_err++; $display("FAIL rstmid wait_lamp got %b exp 0", wait_lamp); end
    n_cmp++; if (dont_walk_lamp !== 1'b1) begin n_err++; $display("FAIL rstmid dont_walk_lamp got %b exp 1", dont_walk_lamp); end
    n_cmp++; if (countdown !== CW'(0)) begin n_err++; $display("FAIL rstmid countdown got %0d exp 0", countdown); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int btn_hold, walk_hold;
    do_reset();
    btn_hold = 0; walk_hold = 20;
    for (int c = 0; c < 4000; c++) begin
      logic          e_pb, e_wl, e_dw;
      logic [CW-1:0] e_cd;
      @(negedge clk);
      e_pb = (m_mode == M_REQ);
      e_wl = (m_mode == M_WALK);
      e_dw = (m_mode == M_WALK) ? 1'b0 :
             (m_mode == M_CLR)  ? (((m_k / FD) % 2) == 0) : 1'b1;
      e_cd = (m_mode == M_CLR) ? CW'(CC - 1 - m_k) : CW'(0);
      n_cmp++; if (pedestrian_button !== e_pb) begin n_err++; $display("FAIL rnd c%0d pedestrian_button got %b exp %b", c, pedestrian_button, e_pb); end
      n_cmp++; if (wait_lamp !== e_pb) begin n_err++; $display("FAIL rnd c%0d wait_lamp got %b exp %b", c, wait_lamp, e_pb); end
      n_cmp++; if (walk_lamp !== e_wl) begin n_err++; $display("FAIL rnd c%0d walk_lamp got %b exp %b", c, walk_lamp, e_wl); end
      n_cmp++; if (dont_walk_lamp !== e_dw) begin n_err++; $display("FAIL rnd c%0d dont_walk_lamp got %b exp %b", c, dont_walk_lamp, e_dw); end
      n_cmp++; if (countdown !== e_cd) begin n_err++; $display("FAIL rnd c%0d countdown got %0d exp %0d", c, countdown, e_cd); end
      if (btn_hold == 0) begin
        btn_raw  = 1'($urandom_range(0, 1));
        btn_hold = int'($urandom_range(1, 12));
      end else begin
        btn_hold--;
      end
      if (walk_hold == 0) begin
        walk      = ~walk;
        walk_hold = walk ? int'($urandom_range(0, 10)) : int'($urandom_range(2, 40));
      end else begin
        walk_hold--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_clearance();
    test_pending();
    test_regrant();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
